// File: rtl/led_pwm_fader.sv
// rtl/led_pwm_fader.sv - per-channel LED brightness ramp rendered by an 8-bit PWM comparator
// Fading is enabled by defining LED_PWM_FADER_FADE_EN; otherwise levels snap to 0/255.
module led_pwm_fader #(
    parameter int TICK_DIV = 1953,
    parameter int STEP     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_port,
    output logic [7:0] led_out,
    output logic       settled
);

    if (TICK_DIV < 1 || STEP < 1 || STEP > 255) begin : g_param_check
        $error("led_pwm_fader: TICK_DIV must be >= 1 and STEP in 1..255");
    end

    logic [7:0] req_q;
    logic [7:0] level [8];

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q <= 8'h00;
        end else begin
            req_q <= in_port;
        end
    end

`ifdef LED_PWM_FADER_FADE_EN
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [7:0]    pwm_cnt;

    assign tick = (tick_cnt == CW'(TICK_DIV - 1));

    // Saturating step toward full-on or off; 9-bit math so the level never wraps.
    function automatic logic [7:0] ramp(input logic [7:0] lvl, input logic up);
        logic [8:0] s;
        if (up) begin
            s = {1'b0, lvl} + 9'(STEP);
            return s[8] ? 8'hFF : s[7:0];
        end else begin
            s = {1'b0, lvl} - 9'(STEP);
            return s[8] ? 8'h00 : s[7:0];
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            pwm_cnt  <= 8'h00;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
            pwm_cnt  <= pwm_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                level[i]   <= 8'h00;
                led_out[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (tick) begin
                    level[i] <= ramp(level[i], req_q[i]);
                end
                // Level 255 is forced on so full brightness has no 1/256 dropout.
                led_out[i] <= (level[i] == 8'hFF) || (level[i] > pwm_cnt);
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                level[i]   <= 8'h00;
                led_out[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                level[i]   <= req_q[i] ? 8'hFF : 8'h00;
                led_out[i] <= (level[i] == 8'hFF);
            end
        end
    end
`endif

    always_comb begin
        settled = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (level[i] != (req_q[i] ? 8'hFF : 8'h00)) begin
                settled = 1'b0;
            end
        end
    end

endmodule
